// File: rtl/chk_pkg.sv
// -----------------------------------------------------------------------------
// chk_pkg
// Shared definitions for the output-checkpoint checker:
//   - chk_state_e  : run-control states (IDLE / RUN / DONE)
//   - chk_entry_t  : one checkpoint table entry {cycle, exp, mask}
//   - LANE_A..D    : bit positions of each lane inside {a,b,c,d} vectors
//   - CHK_DATA_W / CHK_CYC_W : lane and cycle widths the entry struct is built
//     from; the checker's DATA_W / CYC_W parameters default to these and must
//     stay equal to them.
// -----------------------------------------------------------------------------
package chk_pkg;

  localparam int CHK_DATA_W = 8;
  localparam int CHK_CYC_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chk_state_e;

  // Lane positions inside every {a,b,c,d} vector (exp, mask, mismatch).
  localparam int LANE_A = 3;
  localparam int LANE_B = 2;
  localparam int LANE_C = 1;
  localparam int LANE_D = 0;

  typedef struct packed {
    logic [CHK_CYC_W-1:0]    cycle;  // offset from start at which to sample
    logic [3*CHK_DATA_W:0]   exp;    // expected {a,b,c,d}
    logic [3:0]              mask;   // lane enables {a,b,c,d}
  } chk_entry_t;

endpackage

// File: rtl/chk_point_checker_if.sv
// -----------------------------------------------------------------------------
// chk_point_checker_if
// Stimulus-side bus of the checkpoint checker: table programming, run launch
// and the observed outputs of the unit under check.
//   cfg_we / cfg_idx / cfg_cycle / cfg_exp / cfg_mask : table write port
//   cfg_num  : number of active entries, sampled with start
//   start    : run launch pulse
//   obs_a/b/c/d : observed outputs being checked
// Modports:
//   master : drives everything (self-test controller / testbench)
//   slave  : the checker
// -----------------------------------------------------------------------------
interface chk_point_checker_if
  import chk_pkg::*;
#(
  parameter int DATA_W  = CHK_DATA_W,
  parameter int NUM_CHK = 4,
  parameter int CYC_W   = CHK_CYC_W
);

  localparam int IDX_W = $clog2(NUM_CHK);

  logic              cfg_we;
  logic [IDX_W-1:0]  cfg_idx;
  logic [CYC_W-1:0]  cfg_cycle;
  logic [3*DATA_W:0] cfg_exp;
  logic [3:0]        cfg_mask;
  logic [IDX_W:0]    cfg_num;
  logic              start;
  logic [DATA_W-1:0] obs_a;
  logic [DATA_W-1:0] obs_b;
  logic [DATA_W-1:0] obs_c;
  logic              obs_d;

  modport master (
    output cfg_we, cfg_idx, cfg_cycle, cfg_exp, cfg_mask, cfg_num, start,
    output obs_a, obs_b, obs_c, obs_d
  );

  modport slave (
    input cfg_we, cfg_idx, cfg_cycle, cfg_exp, cfg_mask, cfg_num, start,
    input obs_a, obs_b, obs_c, obs_d
  );

endinterface

// File: rtl/chk_lane_cmp.sv
// -----------------------------------------------------------------------------
// chk_lane_cmp
// Combinational masked compare of the observed lanes against an expected
// {a,b,c,d} vector.
//   exp_vec          : expected {a,b,c,d}
//   mask             : lane enables {a,b,c,d}; 0 = lane ignored
//   obs_a/b/c/d      : observed lanes
//   mism             : per-lane masked mismatch {a,b,c,d}
// -----------------------------------------------------------------------------
module chk_lane_cmp
  import chk_pkg::*;
#(
  parameter int DATA_W = CHK_DATA_W
) (
  input  logic [3*DATA_W:0] exp_vec,
  input  logic [3:0]        mask,
  input  logic [DATA_W-1:0] obs_a,
  input  logic [DATA_W-1:0] obs_b,
  input  logic [DATA_W-1:0] obs_c,
  input  logic              obs_d,
  output logic [3:0]        mism
);

  // NOTE: the whole output gets a default first so no path through the block
  // leaves a bit unassigned, which would infer a latch.
  always_comb begin
    mism         = 4'b0000;
    mism[LANE_A] = mask[LANE_A] && (obs_a != exp_vec[3*DATA_W -: DATA_W]);
    mism[LANE_B] = mask[LANE_B] && (obs_b != exp_vec[2*DATA_W -: DATA_W]);
    mism[LANE_C] = mask[LANE_C] && (obs_c != exp_vec[DATA_W   -: DATA_W]);
    mism[LANE_D] = mask[LANE_D] && (obs_d != exp_vec[0]);
  end

endmodule

// File: rtl/chk_point_checker.sv
// -----------------------------------------------------------------------------
// chk_point_checker
// Output-checkpoint checker. After a start pulse it counts cycles and, at each
// programmed checkpoint cycle, compares the observed lanes against the
// programmed expected vector under a per-entry lane mask. Mismatching
// checkpoints are counted (saturating) and pass/fail is reported in DONE.
//
// Ports:
//   clk              : rising-edge clock
//   rst              : asynchronous, active-low reset
//   bus              : chk_point_checker_if.slave (table write, start, obs_*)
//   busy             : run in progress
//   done             : run finished
//   pass             : done with no mismatches and no sequence error
//   err_cnt          : failing checkpoints this run, saturating
//   seq_err          : table found not strictly ascending this run
//   first_fail_idx   : index of first failing checkpoint   (CHK_FIRST_FAIL_EN)
//   first_fail_lanes : its masked mismatch lanes {a,b,c,d} (CHK_FIRST_FAIL_EN)
//
// Build option: define CHK_FIRST_FAIL_EN to add the first-fail capture.
// DATA_W and CYC_W must match the chk_pkg entry widths.
// -----------------------------------------------------------------------------
module chk_point_checker
  import chk_pkg::*;
#(
  parameter int  DATA_W  = CHK_DATA_W,
  parameter int  NUM_CHK = 4,
  parameter int  CYC_W   = CHK_CYC_W,
  parameter int  ERR_W   = 8,
  localparam int IDX_W   = $clog2(NUM_CHK)
) (
  input  logic               clk,
  input  logic               rst,
  chk_point_checker_if.slave bus,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   err_cnt,
  output logic               seq_err
`ifdef CHK_FIRST_FAIL_EN
  ,
  output logic [IDX_W-1:0]   first_fail_idx,
  output logic [3:0]         first_fail_lanes
`endif
);

  localparam logic [1:0]     ST_IDLE = IDLE;
  localparam logic [1:0]     ST_RUN  = RUN;
  localparam logic [1:0]     ST_DONE = DONE;
  localparam logic [IDX_W:0] NUM_MAX = (IDX_W+1)'(NUM_CHK);

  logic [1:0]       state;
  logic [CYC_W-1:0] cyc;
  logic             cyc_ovf;   // cyc has been held at all-ones past one cycle
  logic [IDX_W-1:0] ptr;
  logic [IDX_W:0]   num;
  chk_entry_t       tbl [NUM_CHK];
  chk_entry_t       cur;
  logic [3:0]       mism;
  logic [IDX_W:0]   num_start;
  logic             launch, hit, late, consume, fail, last;

  // NOTE: the checkpoint table is plain storage with no reset; software always
  // programs it before use, and leaving it out of reset keeps it a RAM.
  always_ff @(posedge clk) begin
    if (bus.cfg_we && (state != ST_RUN)) begin
      tbl[bus.cfg_idx] <= '{cycle: bus.cfg_cycle, exp: bus.cfg_exp, mask: bus.cfg_mask};
    end
  end

  assign cur = tbl[ptr];

  chk_lane_cmp #(.DATA_W(DATA_W)) u_cmp (
    .exp_vec (cur.exp),
    .mask    (cur.mask),
    .obs_a   (bus.obs_a),
    .obs_b   (bus.obs_b),
    .obs_c   (bus.obs_c),
    .obs_d   (bus.obs_d),
    .mism    (mism)
  );

  // An oversized entry count is clamped to the table depth.
  assign num_start = (bus.cfg_num > NUM_MAX) ? NUM_MAX : bus.cfg_num;
  assign launch    = bus.start && (state != ST_RUN);

  // Once cyc has sat at all-ones for a cycle, every pending entry is late.
  assign hit     = !cyc_ovf && (cur.cycle == cyc);
  assign late    = cyc_ovf || (cur.cycle < cyc);
  assign consume = (state == ST_RUN) && (hit || late);
  assign fail    = late || (|mism);
  assign last    = ((IDX_W+1)'(ptr) == (num - (IDX_W+1)'(1)));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cyc     <= '0;
      cyc_ovf <= 1'b0;
      ptr     <= '0;
      num     <= '0;
      err_cnt <= '0;
      seq_err <= 1'b0;
    end else if (launch) begin
      state   <= (num_start == '0) ? ST_DONE : ST_RUN;
      cyc     <= '0;
      cyc_ovf <= 1'b0;
      ptr     <= '0;
      num     <= num_start;
      err_cnt <= '0;
      seq_err <= 1'b0;
    end else if (state == ST_RUN) begin
      if (cyc == '1) begin
        cyc_ovf <= 1'b1;
      end else begin
        cyc <= cyc + CYC_W'(1);
      end
      if (consume) begin
        ptr <= ptr + IDX_W'(1);
        if (fail && (err_cnt != '1)) begin
          err_cnt <= err_cnt + ERR_W'(1);
        end
        if (late) begin
          seq_err <= 1'b1;
        end
        if (last) begin
          state <= ST_DONE;
        end
      end
    end
  end

`ifdef CHK_FIRST_FAIL_EN
  logic ff_seen;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ff_seen          <= 1'b0;
      first_fail_idx   <= '0;
      first_fail_lanes <= 4'b0000;
    end else if (launch) begin
      ff_seen          <= 1'b0;
      first_fail_idx   <= '0;
      first_fail_lanes <= 4'b0000;
    end else if (consume && fail && !ff_seen) begin
      ff_seen          <= 1'b1;
      first_fail_idx   <= ptr;
      // A sequence error was never compared, so it records no lanes.
      first_fail_lanes <= late ? 4'b0000 : mism;
    end
  end
`endif

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);
  assign pass = (state == ST_DONE) && (err_cnt == '0) && !seq_err;

endmodule

// File: tb/tb_chk_point_checker.sv
// -----------------------------------------------------------------------------
// tb_chk_point_checker
// Self-checking bench for chk_point_checker. Two checkers share one stimulus
// bus: the default one (ERR_W=8) and a narrow one (ERR_W=2) that shows counter
// saturation. Expected results come from a timeline model: each entry is
// consumed at its own cycle if that lies after the previous consumption,
// otherwise one cycle after it as a sequence error.
// -----------------------------------------------------------------------------
module tb_chk_point_checker;
  import chk_pkg::*;

  localparam int DW   = 8;
  localparam int NC   = 4;
  localparam int CW   = 16;
  localparam int XW   = 3*DW+1;
  localparam int MAXT = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  chk_point_checker_if #(.DATA_W(DW), .NUM_CHK(NC), .CYC_W(CW)) bus ();

  logic       busy, done, pass, seq_err;
  logic [7:0] err_cnt;
  logic       busy2, done2, pass2, seq_err2;
  logic [1:0] err_cnt2;
`ifdef CHK_FIRST_FAIL_EN
  logic [1:0] ff_idx, ff_idx2;
  logic [3:0] ff_lanes, ff_lanes2;
`endif

  chk_point_checker #(.DATA_W(DW), .NUM_CHK(NC), .CYC_W(CW), .ERR_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .busy    (busy),
    .done    (done),
    .pass    (pass),
    .err_cnt (err_cnt),
    .seq_err (seq_err)
`ifdef CHK_FIRST_FAIL_EN
    ,
    .first_fail_idx   (ff_idx),
    .first_fail_lanes (ff_lanes)
`endif
  );

  chk_point_checker #(.DATA_W(DW), .NUM_CHK(NC), .CYC_W(CW), .ERR_W(2)) dut_sat (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .busy    (busy2),
    .done    (done2),
    .pass    (pass2),
    .err_cnt (err_cnt2),
    .seq_err (seq_err2)
`ifdef CHK_FIRST_FAIL_EN
    ,
    .first_fail_idx   (ff_idx2),
    .first_fail_lanes (ff_lanes2)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference copy of the table and the per-cycle observed values.
  int              m_cyc  [NC];
  logic [XW-1:0]   m_exp  [NC];
  logic [3:0]      m_mask [NC];
  logic [DW-1:0]   oa [MAXT];
  logic [DW-1:0]   ob [MAXT];
  logic [DW-1:0]   oc [MAXT];
  logic            od [MAXT];

  // Model results for the current run.
  int   m_err;
  int   m_last;
  logic m_seq;
`ifdef CHK_FIRST_FAIL_EN
  int         m_ffi;
  logic [3:0] m_ffl;
`endif

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic fill_obs();
    for (int t = 0; t < MAXT; t++) begin
      oa[t] = DW'($urandom);
      ob[t] = DW'($urandom);
      oc[t] = DW'($urandom);
      od[t] = 1'($urandom);
    end
  endtask

  task automatic put_obs(input int t, input logic [DW-1:0] a, b, c, input logic d);
    oa[t] = a;
    ob[t] = b;
    oc[t] = c;
    od[t] = d;
  endtask

  task automatic wr(input int k);
    @(negedge clk);
    bus.cfg_we    = 1'b1;
    bus.cfg_idx   = 2'(k);
    bus.cfg_cycle = CW'(m_cyc[k]);
    bus.cfg_exp   = m_exp[k];
    bus.cfg_mask  = m_mask[k];
    @(negedge clk);
    bus.cfg_we    = 1'b0;
  endtask

  task automatic set_entry(input int k, input int cyc, input logic [DW-1:0] a, b, c,
                           input logic d, input logic [3:0] m);
    m_cyc[k]  = cyc;
    m_exp[k]  = {a, b, c, d};
    m_mask[k] = m;
    wr(k);
  endtask

  // Timeline model of one run over the first num entries.
  task automatic model(input int num);
    int         t_prev;
    int         t;
    logic [3:0] lanes;
    bit         failed;
    bit         seen;
    t_prev = -1;
    seen   = 0;
    m_err  = 0;
    m_seq  = 1'b0;
`ifdef CHK_FIRST_FAIL_EN
    m_ffi  = 0;
    m_ffl  = 4'b0000;
`endif
    for (int k = 0; k < num; k++) begin
      if (m_cyc[k] <= t_prev) begin
        t      = t_prev + 1;
        lanes  = 4'b0000;
        failed = 1;
        m_seq  = 1'b1;
      end else begin
        t        = m_cyc[k];
        lanes[3] = m_mask[k][3] && (oa[t] != m_exp[k][3*DW -: DW]);
        lanes[2] = m_mask[k][2] && (ob[t] != m_exp[k][2*DW -: DW]);
        lanes[1] = m_mask[k][1] && (oc[t] != m_exp[k][DW -: DW]);
        lanes[0] = m_mask[k][0] && (od[t] != m_exp[k][0]);
        failed   = (lanes != 4'b0000);
      end
      if (failed) begin
        m_err++;
`ifdef CHK_FIRST_FAIL_EN
        if (!seen) begin
          m_ffi = k;
          m_ffl = lanes;
        end
`endif
        seen = 1;
      end
      t_prev = t;
    end
    m_last = t_prev;
  endtask

  task automatic check_end(input string tag);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    check({tag, "_err"}, 32'(err_cnt), 32'((m_err > 255) ? 255 : m_err));
    check({tag, "_seq"}, 32'(seq_err), 32'(m_seq));
    check({tag, "_pass"}, 32'(pass), 32'(m_err == 0));
    check({tag, "_err_sat"}, 32'(err_cnt2), 32'((m_err > 3) ? 3 : m_err));
    check({tag, "_done_sat"}, 32'(done2), 32'd1);
`ifdef CHK_FIRST_FAIL_EN
    check({tag, "_ff_idx"}, 32'(ff_idx), 32'(m_ffi));
    check({tag, "_ff_lanes"}, 32'(ff_lanes), 32'(m_ffl));
`endif
  endtask

  // Launches a run, feeds obs cycle by cycle and checks the end state at the
  // exact edge the model predicts. A table write during the run must be lost.
  task automatic do_run(input int num, input string tag);
    model(num);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.cfg_num = 3'(num);
    @(negedge clk);
    bus.start   = 1'b0;
    if (num > 0) begin
      for (int n = 0; n <= m_last; n++) begin
        check({tag, "_busy"}, 32'(busy), 32'd1);
        bus.obs_a = oa[n];
        bus.obs_b = ob[n];
        bus.obs_c = oc[n];
        bus.obs_d = od[n];
        if (n == 0) begin
          bus.cfg_we    = 1'b1;
          bus.cfg_idx   = 2'(num - 1);
          bus.cfg_cycle = '0;
          bus.cfg_exp   = XW'($urandom);
          bus.cfg_mask  = 4'hf;
        end else begin
          bus.cfg_we = 1'b0;
        end
        @(negedge clk);
      end
      bus.cfg_we = 1'b0;
    end
    check_end(tag);
  endtask

  initial begin
    bus.cfg_we    = 1'b0;
    bus.cfg_idx   = '0;
    bus.cfg_cycle = '0;
    bus.cfg_exp   = '0;
    bus.cfg_mask  = '0;
    bus.cfg_num   = '0;
    bus.start     = 1'b0;
    bus.obs_a     = '0;
    bus.obs_b     = '0;
    bus.obs_c     = '0;
    bus.obs_d     = 1'b0;

    // Reset state.
    #2 rst = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_err", 32'(err_cnt), 32'd0);
    check("rst_seq", 32'(seq_err), 32'd0);
`ifdef CHK_FIRST_FAIL_EN
    check("rst_ff_idx", 32'(ff_idx), 32'd0);
    check("rst_ff_lanes", 32'(ff_lanes), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;

    // Reference table, all lanes matching: done at start+40 edges.
    fill_obs();
    set_entry(0, 7, 8'd1, 8'd0, 8'd1, 1'b0, 4'hf);
    set_entry(1, 8, 8'd1, 8'd1, 8'd1, 1'b0, 4'hf);
    set_entry(2, 39, 8'd26, 8'd23, 8'd1, 1'b0, 4'hf);
    put_obs(7, 8'd1, 8'd0, 8'd1, 1'b0);
    put_obs(8, 8'd1, 8'd1, 8'd1, 1'b0);
    put_obs(39, 8'd26, 8'd23, 8'd1, 1'b0);
    do_run(3, "plan_match");

    // Same table, b wrong at cycle 39.
    ob[39] = 8'd22;
    do_run(3, "plan_b22");

    // Masked wrong b is ignored; a and c wrong together count once.
    fill_obs();
    set_entry(0, 5, 8'd10, 8'd20, 8'd30, 1'b1, 4'b1011);
    set_entry(1, 12, 8'd40, 8'd50, 8'd60, 1'b0, 4'hf);
    put_obs(5, 8'd10, 8'd99, 8'd30, 1'b1);
    put_obs(12, 8'd41, 8'd50, 8'd61, 1'b0);
    do_run(2, "mask");

    // Descending table {10, 5}.
    fill_obs();
    set_entry(0, 10, 8'd3, 8'd4, 8'd5, 1'b1, 4'hf);
    set_entry(1, 5, 8'd0, 8'd0, 8'd0, 1'b0, 4'hf);
    put_obs(10, 8'd3, 8'd4, 8'd5, 1'b1);
    do_run(2, "seq");

    // Four failing entries: narrow counter saturates at 3.
    fill_obs();
    for (int k = 0; k < NC; k++) begin
      set_entry(k, 3 + 3*k, 8'(k), 8'd7, 8'd9, 1'b0, 4'b1000);
      put_obs(3 + 3*k, 8'(k + 1), 8'd7, 8'd9, 1'b0);
    end
    do_run(4, "saturate");

    // Empty run.
    do_run(0, "num_zero");

    // Randomized tables and observations.
    for (int r = 0; r < 8; r++) begin
      int num;
      int prev;
      num  = int'($urandom_range(1, NC));
      prev = -1;
      fill_obs();
      for (int k = 0; k < num; k++) begin
        int            cyc;
        logic [XW-1:0] e;
        if (k > 0 && $urandom_range(0, 5) == 0) begin
          cyc = (prev > 0) ? prev - int'($urandom_range(0, 1)) : 0;
        end else begin
          cyc = prev + 1 + int'($urandom_range(0, 12));
        end
        if (cyc > prev) prev = cyc;
        e = {oa[cyc], ob[cyc], oc[cyc], od[cyc]};
        if ($urandom_range(0, 1) == 1) e = e ^ XW'(32'd1 << $urandom_range(0, XW - 1));
        m_cyc[k]  = cyc;
        m_exp[k]  = e;
        m_mask[k] = 4'($urandom);
        wr(k);
      end
      do_run(num, $sformatf("rand%0d", r));
    end

    // Reset in the middle of a run, then rerun the retained table.
    fill_obs();
    set_entry(0, 3, 8'd1, 8'd2, 8'd3, 1'b0, 4'hf);
    set_entry(1, 2, 8'd1, 8'd2, 8'd3, 1'b0, 4'hf);
    set_entry(2, 50, 8'd5, 8'd6, 8'd7, 1'b1, 4'hf);
    put_obs(3, 8'd9, 8'd2, 8'd3, 1'b0);
    put_obs(50, 8'd5, 8'd6, 8'd7, 1'b1);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.cfg_num = 3'd3;
    @(negedge clk);
    bus.start   = 1'b0;
    for (int n = 0; n < 20; n++) begin
      bus.obs_a = oa[n];
      bus.obs_b = ob[n];
      bus.obs_c = oc[n];
      bus.obs_d = od[n];
      @(negedge clk);
    end
    check("mid_busy", 32'(busy), 32'd1);
    check("mid_err", 32'(err_cnt), 32'd2);
    check("mid_seq", 32'(seq_err), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_pass", 32'(pass), 32'd0);
    check("abort_err", 32'(err_cnt), 32'd0);
    check("abort_seq", 32'(seq_err), 32'd0);
    check("abort_err_sat", 32'(err_cnt2), 32'd0);
`ifdef CHK_FIRST_FAIL_EN
    check("abort_ff_idx", 32'(ff_idx), 32'd0);
    check("abort_ff_lanes", 32'(ff_lanes), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    do_run(3, "rerun");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chk_point_checker.md
# chk_point_checker

Synthesizable output-checkpoint checker: the hardware consumer of the generated `top` module's observable outputs (`a`, `b`, `c`, `d`). After a start pulse, it counts cycles and samples the observed outputs at programmed checkpoint cycles. Each sample is compared against a programmed expected vector under a per-checkpoint lane mask. Mismatches are counted and the block reports pass/fail. It sits beside the DUT in on-chip self-test builds, giving the same cycle-checkpoint scoreboarding that the simulation benches do.

## Interface
- `DATA_W`, 8, width of observed lanes `a`, `b`, `c`
- `NUM_CHK`, 4, number of checkpoint table entries (power of two, ≥2)
- `CYC_W`, 16, width of the cycle counter and checkpoint cycle fields
- `ERR_W`, 8, width of the error counter
- `clk` input 1 — rising-edge clock
- `rst` input 1 — asynchronous, active-low reset
- `cfg_we` input 1 — table write strobe; ignored unless state is IDLE or DONE
- `cfg_idx` input log2(NUM_CHK) — entry written
- `cfg_cycle` input CYC_W — cycle offset from start at which to sample
- `cfg_exp` input 3*DATA_W+1 — expected {a,b,c,d}
- `cfg_mask` input 4 — lane enables {a,b,c,d}; 0 = lane ignored
- `cfg_num` input log2(NUM_CHK)+1 — active entries, sampled on `start`
- `start` input 1 — launches a run from IDLE or DONE
- `obs_a`, `obs_b`, `obs_c` input DATA_W — observed outputs
- `obs_d` input 1 — observed flag
- `busy` output 1 — state is RUN
- `done` output 1 — state is DONE
- `pass` output 1 — `done` and `err_cnt == 0` and no sequence error
- `err_cnt` output ERR_W — mismatches this run, saturating
- `seq_err` output 1 — sticky; table not strictly ascending
- `first_fail_idx` output log2(NUM_CHK) — only with the macro defined
- `first_fail_lanes` output 4 — only with the macro defined

## Operation
- States: IDLE → RUN on `start`; RUN → DONE when the last active entry is checked; DONE → RUN on `start`.
- `start` while in RUN is ignored.
- `start` with `cfg_num == 0` goes straight to DONE, with `pass=1`.
- On entering RUN: `cyc` = 0, `ptr` = 0, `err_cnt` = 0, `seq_err` = 0, first-fail state cleared.
- In RUN, `cyc` increments every cycle. When `cyc == tbl[ptr].cycle`:
  - compare the masked lanes;
  - on any masked mismatch, increment `err_cnt` (saturating at all-ones);
  - advance `ptr`.
- Sequence error: if `tbl[ptr].cycle < cyc` while `ptr` is active, set `seq_err`, increment `err_cnt`, and advance `ptr` without comparing.
- The table must be strictly ascending, so at most one entry is consumed per cycle.
- `cyc` saturating at all-ones with entries still pending: remaining entries count as sequence errors, one per cycle, then DONE.
- Table writes during RUN are dropped. Table contents are not reset.
- `err_cnt` counts checkpoints, not lanes: a multi-lane mismatch adds 1.

## Timing
- Reset values:
  - `busy` = 0, `done` = 0, `pass` = 0, `err_cnt` = 0, `seq_err` = 0, first-fail outputs = 0;
  - state IDLE; `cyc` = 0; `ptr` = 0.
- `start` sampled at edge S. `cyc` = 0 during cycle S+1, so entry cycle N compares the `obs_*` values present just before edge S+1+N.
- `err_cnt` and `ptr` update at that same edge.
- `done` rises at the edge that consumes the last entry. `busy` falls at that same edge.
- Reset asserted mid-run aborts immediately to IDLE with all outputs at reset values.

## Configuration
- `CHK_FIRST_FAIL_EN` defined:
  - `first_fail_idx` and `first_fail_lanes` exist;
  - they latch the index and the masked-mismatch lane bitmap {a,b,c,d} of the first failing checkpoint in the run;
  - a sequence error records lanes 4'b0000;
  - they hold until the next `start` or reset.
- Not defined: those ports and their registers are absent; all other behaviour is identical.

## Structure
- Shared package `chk_pkg` holds:
  - the state enum (IDLE/RUN/DONE);
  - a checkpoint entry struct {cycle, exp, mask};
  - lane index constants A/B/C/D.
- One sub-module, `chk_lane_cmp`: combinational masked compare returning the 4-bit mismatch vector. All sequencing stays in the top.

## Test plan
- Entries {7: a=1,b=0,c=1,d=0}, {8: a=1,b=1,c=1,d=0}, {39: a=26,b=23,c=1,d=0}, `cfg_num=3`, obs matching → `done` at start+40 edges, `pass=1`, `err_cnt=0`.
- Same table with `obs_b=22` at cycle 39 → `err_cnt=1`, `pass=0`; with the macro, `first_fail_idx=2`, `first_fail_lanes=4'b0100`.
- Entry with `b` masked and a wrong `b` → no error; both `a` and `c` wrong at one entry → `err_cnt` += 1 only.
- Table {10, 5} → `seq_err=1`, `err_cnt=1`, DONE at the edge after cycle 10's check.
- Reset driven low at cycle 20 of a run → all outputs 0 and IDLE asynchronously; a new `start` reruns cleanly.
- `ERR_W=2` with 4 failing entries → `err_cnt` saturates at 3; `cfg_num=0` → immediate `done=1`, `pass=1`.
